// File: rtl/uart_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_loader_pkg
// Purpose : Shared types and constants for the UART bootloader.
//           - rx_state_t   : UART receiver frame states
//           - ld_state_t   : image loader states
//           - LEN_WIDTH    : width of the image-length header
//           - clks_per_bit : baud divisor helper (truncating)
// Rev     : 1.0  initial release
// ============================================================================
package uart_loader_pkg;

  localparam int LEN_WIDTH = 16;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    LD_LEN_LO = 2'd0,
    LD_LEN_HI = 2'd1,
    LD_DATA   = 2'd2,
    LD_DONE   = 2'd3
  } ld_state_t;

  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx
// Purpose : 8N1 UART receiver, LSB first.
// Ports   : clk, rst_n     clock / async active-low reset
//           rxd_i          asynchronous serial input (idle high)
//           rx_valid_o     1-cycle pulse, rx_byte_o holds the received byte
//           rx_byte_o      received byte
//           frame_err_o    1-cycle pulse when a stop bit samples low
// Rev     : 1.0  initial release
// ============================================================================
module uart_rx
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd_i,
  output logic       rx_valid_o,
  output logic [7:0] rx_byte_o,
  output logic       frame_err_o
);

  if (CLKS_PER_BIT < 4) begin : g_bad_divisor
    $error("uart_rx: CLKS_PER_BIT must be >= 4");
  end

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  logic [1:0]       sync_q;
  logic             rxd_s;
  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             stop_bad_q, stop_bad_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  assign rxd_s = sync_q[1];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    bit_d      = bit_q;
    shift_d    = shift_q;
    stop_bad_d = stop_bad_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rxd_s) state_d = RX_START;
      end
      RX_START: begin
        // Mid-start-bit resample: a high here was only a glitch.
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rxd_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rxd_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (stop_bad_q) begin
          // Broken frame: hold off until the line returns to idle so the
          // low stop bit is not mistaken for a new start bit.
          cnt_d = '0;
          if (rxd_s) begin
            stop_bad_d = 1'b0;
            state_d    = RX_IDLE;
          end
        end else if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rxd_s) begin
            valid_d = 1'b1;
            state_d = RX_IDLE;
          end else begin
            err_d      = 1'b1;
            stop_bad_d = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= 2'b11;
      state_q    <= RX_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      stop_bad_q <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], rxd_i};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      stop_bad_q <= stop_bad_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign rx_valid_o  = valid_q;
  assign rx_byte_o   = shift_q;
  assign frame_err_o = err_q;

endmodule
`default_nettype wire

// File: rtl/uart_loader.sv
`default_nettype none
// ============================================================================
// Module  : uart_loader
// Purpose : Serial bootloader. Receives a 16-bit little-endian length header
//           followed by the image bytes over UART and writes them into code
//           memory from address 0, holding the CPU in reset until done.
// Ports   : clk, rst_n     clock / async active-low reset
//           uart_rxd       serial input, 8N1, idle high
//           mem_we         1-cycle write strobe per stored byte
//           mem_addr       write address
//           mem_wdata      write data
//           cpu_rst_n      CPU reset (active low), released when done
//           load_done      sticky image-complete flag
//           load_err       sticky framing / oversize error flag
// Rev     : 1.0  initial release
// ============================================================================
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD        = 115200,
  parameter int ADDR_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  uart_rxd,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  cpu_rst_n,
  output logic                  load_done,
  output logic                  load_err
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);
  // One bit wider than the byte counter so MEM_SIZE = 65536 is representable.
  localparam logic [LEN_WIDTH:0] MEM_SIZE = (LEN_WIDTH + 1)'(2 ** ADDR_WIDTH);

  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       frame_err;

  uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .rxd_i       (uart_rxd),
    .rx_valid_o  (rx_valid),
    .rx_byte_o   (rx_byte),
    .frame_err_o (frame_err)
  );

  ld_state_t             state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  count_q, count_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    count_d = count_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q | frame_err;
    done_d  = done_q | (state_q == LD_DONE);
    case (state_q)
      LD_LEN_LO: begin
        if (rx_valid) begin
          len_d[7:0] = rx_byte;
          state_d    = LD_LEN_HI;
        end
      end
      LD_LEN_HI: begin
        if (rx_valid) begin
          len_d[15:8] = rx_byte;
          count_d     = '0;
          state_d     = ({rx_byte, len_q[7:0]} == '0) ? LD_DONE : LD_DATA;
        end
      end
      LD_DATA: begin
        if (rx_valid) begin
          // Bytes beyond the memory are drained so the header length still
          // terminates the load, but they are flagged and never written.
          if ({1'b0, count_q} < MEM_SIZE) begin
            we_d    = 1'b1;
            addr_d  = count_q[ADDR_WIDTH-1:0];
            wdata_d = rx_byte;
          end else begin
            err_d = 1'b1;
          end
          count_d = count_q + 1'b1;
          if (count_d == len_q) state_d = LD_DONE;
        end
      end
      LD_DONE: ;
      default: state_d = LD_LEN_LO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LD_LEN_LO;
      len_q   <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign load_done = done_q;
  assign cpu_rst_n = done_q;
  assign load_err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_loader
// Purpose : Self-checking bench for uart_loader (10 clocks/bit, 16-byte
//           memory). Expected writes are queued as bytes are sent and
//           matched against each mem_we strobe.
// Rev     : 1.0  initial release
// ============================================================================
module tb_uart_loader;

  localparam int AW  = 4;
  localparam int CPB = 10;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          uart_rxd = 1'b1;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          cpu_rst_n;
  logic          load_done;
  logic          load_err;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  uart_loader #(
    .CLK_FREQ_HZ (1000000),
    .BAUD        (100000),
    .ADDR_WIDTH  (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_rxd  (uart_rxd),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_rst_n (cpu_rst_n),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Matches every write strobe against the scoreboard; also catches
  // back-to-back strobes and writes nobody asked for.
  task automatic monitor();
    logic prev_we;
    wr_t  e;
    prev_we = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && mem_we) begin
        check("we_single_cycle", 32'(prev_we), 32'd0);
        if (exp_q.size() == 0) begin
          check("spurious_we", 32'(mem_we), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(e.addr));
          check("wr_data", 32'(mem_wdata), 32'(e.data));
        end
      end
      prev_we = mem_we;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rxd = stop_bit;
    repeat (CPB) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_data(input logic [7:0] b, input logic [AW-1:0] addr);
    wr_t w;
    w.addr = addr;
    w.data = b;
    exp_q.push_back(w);
    send_byte(b, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    uart_rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},    32'(mem_we),    32'd0);
    check({tag, "_addr"},  32'(mem_addr),  32'd0);
    check({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_cpu"},   32'(cpu_rst_n), 32'd0);
    check({tag, "_done"},  32'(load_done), 32'd0);
    check({tag, "_err"},   32'(load_err),  32'd0);
  endtask

  task automatic check_end(input string tag, input logic done, input logic err);
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_done"},    32'(load_done),     32'(done));
    check({tag, "_cpu"},     32'(cpu_rst_n),     32'(done));
    check({tag, "_err"},     32'(load_err),      32'(err));
  endtask

  initial begin
    fork
      monitor();
    join_none

    // Reset values
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic 3-byte image
    send_byte(8'h03, 1'b1);
    send_byte(8'h00, 1'b1);
    send_data(8'hA9, 4'd0);
    check("basic_done_early", 32'(load_done), 32'd0);
    send_data(8'h42, 4'd1);
    send_data(8'hEA, 4'd2);
    check_end("basic", 1'b1, 1'b0);

    // Zero-length image, then a byte after DONE
    do_reset();
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    check_end("len0", 1'b1, 1'b0);
    send_byte(8'h55, 1'b1);
    check_end("after_done", 1'b1, 1'b0);

    // Glitch rejection, framing error, then a good load
    do_reset();
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (3) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_err", 32'(load_err), 32'd0);
    send_byte(8'h77, 1'b0);
    check("frame_err", 32'(load_err), 32'd1);
    check("frame_done", 32'(load_done), 32'd0);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_data(8'h5A, 4'd0);
    check_end("after_frame", 1'b1, 1'b1);

    // Oversize image: 18 bytes into 16 locations
    do_reset();
    send_byte(8'h12, 1'b1);
    send_byte(8'h00, 1'b1);
    for (int i = 0; i < 16; i++) send_data(8'(i), AW'(i));
    check("ovf_err_at_16", 32'(load_err), 32'd0);
    send_byte(8'h10, 1'b1);
    check("ovf_err_at_17", 32'(load_err), 32'd1);
    check("ovf_done_at_17", 32'(load_done), 32'd0);
    send_byte(8'h11, 1'b1);
    check_end("ovf", 1'b1, 1'b1);

    // Asynchronous reset in the middle of the data phase, then full reload
    do_reset();
    send_byte(8'h03, 1'b1);
    send_byte(8'h00, 1'b1);
    send_data(8'hA9, 4'd0);
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (15) @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_reset_outputs("async_rst");
    uart_rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_byte(8'h03, 1'b1);
    send_byte(8'h00, 1'b1);
    send_data(8'hA9, 4'd0);
    send_data(8'h42, 4'd1);
    send_data(8'hEA, 4'd2);
    check_end("reload", 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
